operand_streamer: RTL

Fetches pairs of tagged 128-bit operand blocks from the shared block SRAM and broadcasts them on the two operand buses feeding a stripe of processing elements. It walks two tag sequences, A and B, each with its own base and stride, for a programmed number of pairs. Each pair is emitted as one tagged broadcast so the stripe's tag match can latch the operands. It sits directly upstream of the stripe, between the SRAM read port and the d0/d1 operand buses.

---
 rtl/operand_streamer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/operand_streamer.sv
// Fetches A/B operand block pairs from the block SRAM along two strided tag
// sequences and broadcasts each pair as one tagged transfer to the PE stripe.
module operand_streamer #(
   parameter int block_width = 128,
   parameter int tag_width   = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [tag_width-1:0]   cfg_tag_a,
   input  logic [tag_width-1:0]   cfg_tag_b,
   input  logic [tag_width-1:0]   cfg_stride_a,
   input  logic [tag_width-1:0]   cfg_stride_b,
   input  logic [tag_width-1:0]   cfg_count,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_req,
   output logic [tag_width-1:0]   mem_addr,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [block_width-1:0] mem_rdata,
   input  logic                   hold,
   output logic                   bus_valid,
   output logic [tag_width-1:0]   tagA_OUT,
   output logic [tag_width-1:0]   tagB_OUT,
   output logic [block_width-1:0] d0_OUT,
   output logic [block_width-1:0] d1_OUT
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] REQ_A  = 3'd1;
   localparam logic [2:0] WAIT_A = 3'd2;
   localparam logic [2:0] REQ_B  = 3'd3;
   localparam logic [2:0] WAIT_B = 3'd4;
   localparam logic [2:0] EMIT   = 3'd5;

   localparam logic [tag_width-1:0] one_tag = {{(tag_width-1){1'b0}}, 1'b1};

   logic [2:0]             state;
   logic [tag_width-1:0]   cur_a;
   logic [tag_width-1:0]   cur_b;
   logic [tag_width-1:0]   stride_a;
   logic [tag_width-1:0]   stride_b;
   logic [tag_width-1:0]   rem;
   logic [block_width-1:0] data_a;

   // The bus registers double as the B capture register and keep their last
   // values between emits, so consumers must qualify on bus_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_a    <= '0;
         cur_b    <= '0;
         stride_a <= '0;
         stride_b <= '0;
         rem      <= '0;
         data_a   <= '0;
         done     <= 1'b0;
         tagA_OUT <= '0;
         tagB_OUT <= '0;
         d0_OUT   <= '0;
         d1_OUT   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cur_a    <= cfg_tag_a;
                  cur_b    <= cfg_tag_b;
                  stride_a <= cfg_stride_a;
                  stride_b <= cfg_stride_b;
                  rem      <= cfg_count;
                  if (cfg_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= REQ_A;
                  end
               end
            end
            REQ_A: begin
               if (mem_gnt) begin
                  state <= WAIT_A;
               end
            end
            WAIT_A: begin
               if (mem_rvalid) begin
                  data_a <= mem_rdata;
                  state  <= REQ_B;
               end
            end
            REQ_B: begin
               if (mem_gnt) begin
                  state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (mem_rvalid) begin
                  tagA_OUT <= cur_a;
                  tagB_OUT <= cur_b;
                  d0_OUT   <= data_a;
                  d1_OUT   <= mem_rdata;
                  state    <= EMIT;
               end
            end
            EMIT: begin
               // Tags wrap modulo 2^tag_width; the last pair retires the job.
               if (!hold) begin
                  cur_a <= cur_a + stride_a;
                  cur_b <= cur_b + stride_b;
                  rem   <= rem - one_tag;
                  if (rem == one_tag) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     state <= REQ_A;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign bus_valid = (state == EMIT);
   assign mem_req   = (state == REQ_A) || (state == REQ_B);
   assign mem_addr  = (state == REQ_B) ? cur_b :
                      (state == REQ_A) ? cur_a : '0;

endmodule
